// File: rtl/renode_apb_pkg.sv
// Shared types for the Renode APB requester: FSM states, the response record
// and the DataWidth legality check.
package renode_apb_pkg;

    localparam int MAX_DW = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // rdata is sized for the widest legal bus; the top slices it down.
    typedef struct packed {
        logic [MAX_DW-1:0] rdata;
        logic              error;
        logic              timeout;
    } rsp_t;

    function automatic bit legal_data_width(input int w);
        return (w == 8) || (w == 16) || (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/renode_irq_capture.sv
// Interrupt capture: 2-flop synchroniser, rising-edge detect and sticky
// pending bits with a per-bit clear (a same-cycle edge wins over clear).
module renode_irq_capture #(
    parameter int InterruptCount = 4
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [InterruptCount-1:0] irq_in,
    input  logic [InterruptCount-1:0] irq_clear,
    output logic [InterruptCount-1:0] irq_pending
);

    logic [InterruptCount-1:0] sync1_q, sync2_q, prev_q, rise;

    assign rise = sync2_q & ~prev_q;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            irq_pending <= '0;
        end else begin
            sync1_q     <= irq_in;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            irq_pending <= (irq_pending & ~irq_clear) | rise;
        end
    end

endmodule

// File: rtl/renode_apb_requester.sv
// APB manager for the Renode bus layer: valid/ready request in, APB
// SETUP/ACCESS with wait states and timeout, valid/ready response out.
// Define RENODE_APB_PSTRB_EN for the APB4 pstrb port; otherwise writes are full-width APB3.
module renode_apb_requester
    import renode_apb_pkg::*;
#(
    parameter int AddressWidth   = 20,
    parameter int DataWidth      = 32,
    parameter int TimeoutCycles  = 256,
    parameter int InterruptCount = 4
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [AddressWidth-1:0]   req_addr,
    input  logic [DataWidth-1:0]      req_wdata,
    input  logic [DataWidth/8-1:0]    req_strb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DataWidth-1:0]      rsp_rdata,
    output logic                      rsp_error,
    output logic                      rsp_timeout,
    output logic [AddressWidth-1:0]   paddr,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DataWidth-1:0]      pwdata,
`ifdef RENODE_APB_PSTRB_EN
    output logic [DataWidth/8-1:0]    pstrb,
`endif
    input  logic                      pready,
    input  logic [DataWidth-1:0]      prdata,
    input  logic                      pslverr,
    input  logic [InterruptCount-1:0] irq_in,
    input  logic [InterruptCount-1:0] irq_clear,
    output logic [InterruptCount-1:0] irq_pending
);

    if (!legal_data_width(DataWidth)) begin : g_bad_dw
        $error("renode_apb_requester: illegal DataWidth %0d", DataWidth);
    end

    localparam int StrbW   = DataWidth / 8;
    localparam int AddrLsb = $clog2(StrbW);
    localparam int CntW    = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] TimeoutLim = CntW'(TimeoutCycles);
    localparam logic [AddressWidth-1:0] AddrMask =
        ~((AddressWidth'(1) << AddrLsb) - AddressWidth'(1));

    state_e                  state_q, state_d;
    logic                    write_q;
    logic [AddressWidth-1:0] addr_q;
    logic [DataWidth-1:0]    wdata_q;
    logic [CntW-1:0]         wait_cnt, cnt_inc;
    logic                    timeout_hit;
    rsp_t                    rsp_q;

    // cnt_inc is the number of ACCESS cycles including the current one.
    assign cnt_inc     = wait_cnt + CntW'(1);
    assign timeout_hit = (TimeoutCycles != 0) && !pready && (cnt_inc == TimeoutLim);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // req_ready is held low for the whole reset assertion.
    always_comb begin
        req_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE:    req_ready = ~preset;
            SETUP:   psel = 1'b1;
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wait_cnt <= '0;
            rsp_q    <= '0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                write_q  <= req_write;
                addr_q   <= req_addr & AddrMask;
                wdata_q  <= req_wdata;
                wait_cnt <= '0;
            end
            if (state_q == ACCESS) begin
                if (pready) begin
                    rsp_q.rdata   <= write_q ? '0 : MAX_DW'(prdata);
                    rsp_q.error   <= pslverr;
                    rsp_q.timeout <= 1'b0;
                end else begin
                    wait_cnt <= cnt_inc;
                    if (timeout_hit) begin
                        rsp_q.rdata   <= '0;
                        rsp_q.error   <= 1'b1;
                        rsp_q.timeout <= 1'b1;
                    end
                end
            end
        end
    end

    assign paddr       = addr_q;
    assign pwrite      = write_q;
    assign pwdata      = wdata_q;
    assign rsp_rdata   = rsp_q.rdata[DataWidth-1:0];
    assign rsp_error   = rsp_q.error;
    assign rsp_timeout = rsp_q.timeout;

    logic unused_rsp_hi;
    assign unused_rsp_hi = ^rsp_q.rdata;

`ifdef RENODE_APB_PSTRB_EN
    logic [StrbW-1:0] strb_q;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset)                         strb_q <= '0;
        else if (state_q == IDLE && req_valid) strb_q <= req_strb;
    end

    assign pstrb = (psel && write_q) ? strb_q : '0;
`else
    logic unused_strb;
    assign unused_strb = ^req_strb;
`endif

    renode_irq_capture #(
        .InterruptCount(InterruptCount)
    ) u_irq (
        .pclk        (pclk),
        .preset      (preset),
        .irq_in      (irq_in),
        .irq_clear   (irq_clear),
        .irq_pending (irq_pending)
    );

endmodule
